// File: rtl/lvt_mpram_nwnr.sv
// Live-Value-Table multiported RAM: NW write ports, NR read ports, one bank per
// (writer, reader) pair, with a last-writer table selecting the live bank on read.
module lvt_mpram_nwnr #(
    parameter int NW     = 8,
    parameter int NR     = 8,
    parameter int DW     = 32,
    parameter int AW     = 11,
    parameter int BYPASS = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [NW-1:0]      en_w,
    input  logic [NW*AW-1:0]   w_addr,
    input  logic [NW*DW-1:0]   w_din,
    input  logic [NR*AW-1:0]   r_addr,
    output logic [NR*DW-1:0]   r_dout,
    output logic               busy,
    output logic               wr_conflict,
    output logic               fsm_state
);

    localparam int DEPTH = 2 ** AW;
    localparam int LW    = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_next;
    logic            ready;

    logic [AW-1:0]   wa [NW];
    logic [DW-1:0]   wd [NW];
    logic [AW-1:0]   ra [NR];

    logic [NW-1:0]   win;
    logic            conflict;

    logic [LW-1:0]   lvt [DEPTH];
    logic [LW-1:0]   lvt_rd [NR];
    logic [DW-1:0]   rd_word [NW][NR];
    logic [DW-1:0]   rd_next [NR];

    assign ready     = (state == S_READY);
    assign busy      = (state == S_CLEAR);
    assign fsm_state = logic'(state);

    always_comb begin
        for (int i = 0; i < NW; i++) begin
            wa[i] = w_addr[i*AW +: AW];
            wd[i] = w_din[i*DW +: DW];
        end
        for (int j = 0; j < NR; j++) begin
            ra[j] = r_addr[j*AW +: AW];
        end
    end

    // A port wins its address only if no higher-index enabled port targets it too.
    always_comb begin
        win = '0;
        for (int i = 0; i < NW; i++) begin
            win[i] = en_w[i];
            for (int k = i + 1; k < NW; k++) begin
                if (en_w[k] && (wa[k] == wa[i])) begin
                    win[i] = 1'b0;
                end
            end
        end
        conflict = |(en_w & ~win);
    end

    // Clear sequencer: walks every address once, then hands over to normal operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_CLEAR: begin
                if (cnt == '1) begin
                    state_next = S_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_READY: begin
                if (clr) begin
                    state_next = S_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = S_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // Only winners record themselves, so the table always names the live bank.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            lvt[cnt] <= '0;
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (win[i]) begin
                    lvt[wa[i]] <= LW'(i);
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NR; j++) begin
            lvt_rd[j] = lvt[ra[j]];
        end
    end

    for (genvar gi = 0; gi < NW; gi++) begin : g_wr
        localparam bit CLR_BANK = (gi == 0);
        for (genvar gj = 0; gj < NR; gj++) begin : g_rd
            logic [DW-1:0] mem [DEPTH];

            // Clearing bank row 0 suffices because the cleared LVT points every address there.
            always_ff @(posedge clk) begin
                if (state == S_CLEAR) begin
                    if (CLR_BANK) begin
                        mem[cnt] <= '0;
                    end
                end else if (en_w[gi]) begin
                    mem[wa[gi]] <= wd[gi];
                end
            end

            assign rd_word[gi][gj] = mem[ra[gj]];
        end
    end

    always_comb begin
        for (int j = 0; j < NR; j++) begin
            rd_next[j] = '0;
            for (int i = 0; i < NW; i++) begin
                if (lvt_rd[j] == LW'(i)) begin
                    rd_next[j] = rd_word[i][j];
                end
            end
            if (BYPASS != 0) begin
                for (int i = 0; i < NW; i++) begin
                    if (win[i] && (wa[i] == ra[j])) begin
                        rd_next[j] = wd[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout      <= '0;
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= ready && conflict;
            for (int j = 0; j < NR; j++) begin
                r_dout[j*DW +: DW] <= ready ? rd_next[j] : '0;
            end
        end
    end

endmodule

// File: tb/tb_lvt_mpram_nwnr.sv
// Bench for lvt_mpram_nwnr: read-old and write-first instances share stimulus and
// are scored against a single behavioural memory model.
module tb_lvt_mpram_nwnr;

    localparam int NW    = 8;
    localparam int NR    = 8;
    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int DEPTH = 2 ** AW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clr = 1'b0;
    logic [NW-1:0]     en_w = '0;
    logic [NW*AW-1:0]  w_addr;
    logic [NW*DW-1:0]  w_din;
    logic [NR*AW-1:0]  r_addr;
    logic [NR*DW-1:0]  r_dout_a, r_dout_b;
    logic              busy_a, busy_b;
    logic              wc_a, wc_b;
    logic              st_a, st_b;

    logic [AW-1:0]     wa [NW];
    logic [DW-1:0]     wd [NW];
    logic [AW-1:0]     ra [NR];

    logic [DW-1:0]     model_mem [DEPTH];
    logic [DW-1:0]     exp_q[$];
    logic [DW-1:0]     exp_b_q[$];
    logic              exp_wc;
    int                n_checks = 0;
    int                n_fail   = 0;

    lvt_mpram_nwnr #(.NW(NW), .NR(NR), .DW(DW), .AW(AW), .BYPASS(0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .en_w(en_w), .w_addr(w_addr), .w_din(w_din),
        .r_addr(r_addr), .r_dout(r_dout_a), .busy(busy_a), .wr_conflict(wc_a), .fsm_state(st_a)
    );

    lvt_mpram_nwnr #(.NW(NW), .NR(NR), .DW(DW), .AW(AW), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .en_w(en_w), .w_addr(w_addr), .w_din(w_din),
        .r_addr(r_addr), .r_dout(r_dout_b), .busy(busy_b), .wr_conflict(wc_b), .fsm_state(st_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always_comb begin
        w_addr = '0;
        w_din  = '0;
        r_addr = '0;
        for (int i = 0; i < NW; i++) begin
            w_addr[i*AW +: AW] = wa[i];
            w_din[i*DW +: DW]  = wd[i];
        end
        for (int j = 0; j < NR; j++) begin
            r_addr[j*AW +: AW] = ra[j];
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_w = '0;
        clr  = 1'b0;
        for (int i = 0; i < NW; i++) begin
            wa[i] = '0;
            wd[i] = '0;
        end
        for (int j = 0; j < NR; j++) begin
            ra[j] = '0;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            model_mem[k] = '0;
        end
    endtask

    // Read-old expectations come from the model before the writes, write-first
    // expectations from the model after them; ascending port order makes the
    // highest-index writer the survivor.
    task automatic commit();
        for (int j = 0; j < NR; j++) begin
            exp_q.push_back(model_mem[ra[j]]);
        end
        exp_wc = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (en_w[i]) begin
                for (int k = 0; k < i; k++) begin
                    if (en_w[k] && (wa[k] == wa[i])) exp_wc = 1'b1;
                end
                model_mem[wa[i]] = wd[i];
            end
        end
        for (int j = 0; j < NR; j++) begin
            exp_b_q.push_back(model_mem[ra[j]]);
        end
        step();
    endtask

    task automatic count_busy(output int cyc);
        cyc = 0;
        while (busy_a === 1'b1 && cyc < DEPTH + 100) begin
            step();
            cyc++;
        end
    endtask

    // test scenarios
    task automatic test_reset();
        logic [DW-1:0] e, eb;
        int cyc;
        idle();
        rst = 1'b0;
        step();
        step();
        n_checks += 4;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy: got %b/%b want 1", busy_a, busy_b);
        end
        if (r_dout_a !== '0 || r_dout_b !== '0) begin
            n_fail++; $display("FAIL reset_rdout: got %h / %h want 0", r_dout_a, r_dout_b);
        end
        if (wc_a !== 1'b0 || wc_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_wc: got %b/%b want 0", wc_a, wc_b);
        end
        if (st_a !== st_b) begin
            n_fail++; $display("FAIL reset_state_agree: got %b/%b want equal", st_a, st_b);
        end
        rst = 1'b1;
        count_busy(cyc);
        n_checks += 2;
        if (cyc != DEPTH) begin
            n_fail++; $display("FAIL reset_busy_len: got %0d want %0d", cyc, DEPTH);
        end
        if (busy_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_b_done: got %b want 0", busy_b);
        end
        model_clear();
        for (int j = 0; j < NR; j++) begin
            ra[j] = (j % 3 == 0) ? AW'(0) : (j % 3 == 1) ? AW'(5) : AW'(DEPTH - 1);
        end
        commit();
        for (int j = 0; j < NR; j++) begin
            e = exp_q.pop_front(); eb = exp_b_q.pop_front();
            n_checks += 2;
            if (r_dout_a[j*DW +: DW] !== e) begin
                n_fail++; $display("FAIL reset_read_a port %0d: got %h want %h", j, r_dout_a[j*DW +: DW], e);
            end
            if (r_dout_b[j*DW +: DW] !== eb) begin
                n_fail++; $display("FAIL reset_read_b port %0d: got %h want %h", j, r_dout_b[j*DW +: DW], eb);
            end
        end
    endtask

    task automatic test_disjoint();
        logic [DW-1:0] e, eb;
        for (int pass = 0; pass < 2; pass++) begin
            idle();
            for (int k = 0; k < NW; k++) begin
                if (pass == 0) begin
                    en_w[k] = 1'b1;
                    wa[k]   = AW'(100 + k);
                    wd[k]   = DW'(32'h10 + k);
                end
            end
            for (int j = 0; j < NR; j++) ra[j] = (pass == 0) ? AW'(0) : AW'(100 + j);
            commit();
            for (int j = 0; j < NR; j++) begin
                e = exp_q.pop_front(); eb = exp_b_q.pop_front();
                n_checks += 2;
                if (r_dout_a[j*DW +: DW] !== e) begin
                    n_fail++; $display("FAIL disjoint_a pass %0d port %0d: got %h want %h", pass, j, r_dout_a[j*DW +: DW], e);
                end
                if (r_dout_b[j*DW +: DW] !== eb) begin
                    n_fail++; $display("FAIL disjoint_b pass %0d port %0d: got %h want %h", pass, j, r_dout_b[j*DW +: DW], eb);
                end
            end
            n_checks++;
            if (wc_a !== exp_wc || wc_b !== exp_wc) begin
                n_fail++; $display("FAIL disjoint_wc pass %0d: got %b/%b want %b", pass, wc_a, wc_b, exp_wc);
            end
        end
    endtask

    task automatic test_conflict();
        logic [DW-1:0] e, eb;
        for (int pass = 0; pass < 2; pass++) begin
            idle();
            if (pass == 0) begin
                en_w[2] = 1'b1; wa[2] = AW'(300); wd[2] = 32'hAA;
                en_w[5] = 1'b1; wa[5] = AW'(300); wd[5] = 32'hBB;
                en_w[6] = 1'b1; wa[6] = AW'(300); wd[6] = 32'hCC;
            end
            for (int j = 0; j < NR; j++) ra[j] = AW'(300);
            commit();
            for (int j = 0; j < NR; j++) begin
                e = exp_q.pop_front(); eb = exp_b_q.pop_front();
                n_checks += 2;
                if (r_dout_a[j*DW +: DW] !== e) begin
                    n_fail++; $display("FAIL conflict_a pass %0d port %0d: got %h want %h", pass, j, r_dout_a[j*DW +: DW], e);
                end
                if (r_dout_b[j*DW +: DW] !== eb) begin
                    n_fail++; $display("FAIL conflict_b pass %0d port %0d: got %h want %h", pass, j, r_dout_b[j*DW +: DW], eb);
                end
            end
            n_checks++;
            if (wc_a !== exp_wc || wc_b !== exp_wc) begin
                n_fail++; $display("FAIL conflict_wc pass %0d: got %b/%b want %b", pass, wc_a, wc_b, exp_wc);
            end
        end
        n_checks++;
        if (dut_a.lvt[300] !== 3'd6 || dut_b.lvt[300] !== 3'd6) begin
            n_fail++; $display("FAIL conflict_lvt: got %0d/%0d want 6", dut_a.lvt[300], dut_b.lvt[300]);
        end
    endtask

    task automatic test_rdw();
        logic [DW-1:0] e, eb;
        for (int pass = 0; pass < 3; pass++) begin
            idle();
            if (pass == 0) begin
                en_w[1] = 1'b1; wa[1] = AW'(7); wd[1] = 32'h11;
            end else if (pass == 1) begin
                en_w[3] = 1'b1; wa[3] = AW'(7); wd[3] = 32'h22;
            end
            for (int j = 0; j < NR; j++) ra[j] = AW'(7);
            commit();
            for (int j = 0; j < NR; j++) begin
                e = exp_q.pop_front(); eb = exp_b_q.pop_front();
                n_checks += 2;
                if (r_dout_a[j*DW +: DW] !== e) begin
                    n_fail++; $display("FAIL rdw_a pass %0d port %0d: got %h want %h", pass, j, r_dout_a[j*DW +: DW], e);
                end
                if (r_dout_b[j*DW +: DW] !== eb) begin
                    n_fail++; $display("FAIL rdw_b pass %0d port %0d: got %h want %h", pass, j, r_dout_b[j*DW +: DW], eb);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e, eb;
        for (int it = 0; it < 60; it++) begin
            idle();
            en_w = NW'($urandom_range(0, 255));
            for (int i = 0; i < NW; i++) begin
                wa[i] = AW'(500 + $urandom_range(0, 7));
                wd[i] = $urandom;
            end
            for (int j = 0; j < NR; j++) ra[j] = AW'(500 + $urandom_range(0, 7));
            commit();
            for (int j = 0; j < NR; j++) begin
                e = exp_q.pop_front(); eb = exp_b_q.pop_front();
                n_checks += 2;
                if (r_dout_a[j*DW +: DW] !== e) begin
                    n_fail++; $display("FAIL b2b_a it %0d port %0d: got %h want %h", it, j, r_dout_a[j*DW +: DW], e);
                end
                if (r_dout_b[j*DW +: DW] !== eb) begin
                    n_fail++; $display("FAIL b2b_b it %0d port %0d: got %h want %h", it, j, r_dout_b[j*DW +: DW], eb);
                end
            end
            n_checks++;
            if (wc_a !== exp_wc || wc_b !== exp_wc) begin
                n_fail++; $display("FAIL b2b_wc it %0d: got %b/%b want %b", it, wc_a, wc_b, exp_wc);
            end
        end
    endtask

    task automatic test_mid_clear();
        logic [DW-1:0] e, eb;
        logic wc_seen, dout_nonzero;
        int cyc;
        for (int pass = 0; pass < 2; pass++) begin
            idle();
            if (pass == 0) begin
                en_w[4] = 1'b1; wa[4] = AW'(9); wd[4] = 32'h55;
            end
            ra[0] = AW'(9);
            commit();
            for (int j = 0; j < NR; j++) begin
                e = exp_q.pop_front(); eb = exp_b_q.pop_front();
                n_checks += 2;
                if (r_dout_a[j*DW +: DW] !== e) begin
                    n_fail++; $display("FAIL midclr_pre_a pass %0d port %0d: got %h want %h", pass, j, r_dout_a[j*DW +: DW], e);
                end
                if (r_dout_b[j*DW +: DW] !== eb) begin
                    n_fail++; $display("FAIL midclr_pre_b pass %0d port %0d: got %h want %h", pass, j, r_dout_b[j*DW +: DW], eb);
                end
            end
        end
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            n_fail++; $display("FAIL midclr_busy_start: got %b/%b want 1", busy_a, busy_b);
        end
        en_w[0] = 1'b1; wa[0] = AW'(9); wd[0] = 32'h77;
        en_w[1] = 1'b1; wa[1] = AW'(9); wd[1] = 32'h88;
        ra[0] = AW'(9);
        wc_seen = 1'b0;
        dout_nonzero = 1'b0;
        for (int c = 1; c < 1000; c++) begin
            if (c == 2) idle();
            step();
            wc_seen = wc_seen | wc_a | wc_b;
            dout_nonzero = dout_nonzero | (|r_dout_a) | (|r_dout_b);
        end
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            n_fail++; $display("FAIL midclr_busy_mid: got %b/%b want 1", busy_a, busy_b);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        count_busy(cyc);
        n_checks += 3;
        if (cyc != DEPTH) begin
            n_fail++; $display("FAIL midclr_busy_len: got %0d want %0d", cyc, DEPTH);
        end
        if (wc_seen !== 1'b0) begin
            n_fail++; $display("FAIL midclr_wc: got %b want 0", wc_seen);
        end
        if (dout_nonzero !== 1'b0) begin
            n_fail++; $display("FAIL midclr_dout_forced: got %b want 0", dout_nonzero);
        end
        model_clear();
        idle();
        for (int j = 0; j < NR; j++) ra[j] = AW'(9);
        commit();
        for (int j = 0; j < NR; j++) begin
            e = exp_q.pop_front(); eb = exp_b_q.pop_front();
            n_checks += 2;
            if (r_dout_a[j*DW +: DW] !== e) begin
                n_fail++; $display("FAIL midclr_final_a port %0d: got %h want %h", j, r_dout_a[j*DW +: DW], e);
            end
            if (r_dout_b[j*DW +: DW] !== eb) begin
                n_fail++; $display("FAIL midclr_final_b port %0d: got %h want %h", j, r_dout_b[j*DW +: DW], eb);
            end
        end
    endtask

    initial begin
        idle();
        model_clear();
        test_reset();
        test_disjoint();
        test_conflict();
        test_rdw();
        test_back_to_back();
        test_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lvt_mpram_nwnr.md
Name: lvt_mpram_nwnr

Overview:
- Parametrised Live-Value-Table multiported RAM with NW write ports and NR read ports.
- Successor to the fixed 8W/8R, 32-bit LVT memory. Generalises port count, width and depth.
- Adds three behaviours the fixed block lacks: a selectable read-during-write mode, deterministic same-address write-conflict resolution with a flag, and a hardware clear sequencer.
- Sits as the shared register/scratch store in the multi-issue datapath.

Parameters:
- NW, 8, number of write ports (1..16).
- NR, 8, number of read ports (1..16).
- DW, 32, data width.
- AW, 11, address width; DEPTH = 2**AW entries.
- BYPASS, 0, 0 = read-old (read-before-write); 1 = write-first (same-cycle write data forwarded to the read).
- LW, derived, LVT entry width = max(1, clog2(NW)).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-low reset.
- clr  in  1  start-clear request; single-cycle pulse, sampled only in READY.
- en_w  in  NW  per-port write enable; bit i belongs to port i.
- w_addr  in  NW*AW  write addresses; port i at [i*AW +: AW].
- w_din  in  NW*DW  write data; port i at [i*DW +: DW].
- r_addr  in  NR*AW  read addresses; port j at [j*AW +: AW].
- r_dout  out  NR*DW  registered read data; port j at [j*DW +: DW].
- busy  out  1  high while the clear sequence runs.
- wr_conflict  out  1  registered pulse: two or more enabled write ports hit the same address in the previous cycle.

Behaviour:
- Storage: NW×NR banks, each DEPTH×DW. Bank (i,j) is written only by write port i and read only by read port j. The LVT is a DEPTH×LW table recording the last writer of each address.
- Write, cycle t: for each enabled port i, bank (i,*) gets w_din_i at w_addr_i, and LVT[w_addr_i] gets i.
- Conflicts: if enabled ports share an address, the highest-index enabled port wins. Its data and index are stored; the lower-index ports' LVT updates are suppressed. Their bank writes still happen but are dead. wr_conflict = 1 in cycle t+1 only.
- Read latency is 1. r_addr presented before edge t gives r_dout valid after edge t, held until the next edge. The value is bank(LVT[a], j)[a].
- BYPASS=0: the read returns memory contents before any write at edge t.
- BYPASS=1: if any enabled write in the same cycle targets r_addr_j, r_dout_j returns the winning write's w_din. This is a combinational compare into the output register.
- Reset (rst=0, async):
  - r_dout = 0, wr_conflict = 0, busy = 1, FSM enters CLEAR with counter = 0.
  - Array contents are not reset directly; the CLEAR pass zeroes them.
- FSM states:
  - CLEAR: each cycle, write LVT[cnt] = 0 and bank(0,*)[cnt] = 0, then cnt += 1. When cnt = DEPTH-1 is written, go to READY the next edge. This takes exactly DEPTH cycles.
  - READY: busy = 0 and normal operation. clr = 1 → CLEAR with cnt = 0, busy = 1 from the next edge.
- During CLEAR:
  - en_w is ignored (no bank or LVT update, no wr_conflict).
  - r_dout is forced to 0.
  - clr is ignored.
- Counter: AW bits wide; terminal count is detected, never wrapped. A new clr in READY always restarts from 0.
- rst asserted mid-CLEAR restarts CLEAR from 0. rst asserted mid-write drops that write.
- Ports whose en_w bit is 0 have no effect regardless of address or data.

Test Plan:
- Reset then clear:
  - Stimulus: rst low 2 cycles, release; hold all en_w = 0.
  - Required: busy = 1 for exactly DEPTH = 2048 cycles, then 0. Reads of 0, 5 and 2047 on all ports return 0.
- Disjoint writes:
  - Stimulus (after clear): port k writes 0x10+k to address 100+k, k = 0..7. Next cycle, read port j reads address 100+j.
  - Required: r_dout_j = 0x10+j one cycle after the read is presented; wr_conflict stays 0.
- Conflict:
  - Stimulus: ports 2, 5 and 6 write 0xAA, 0xBB and 0xCC to address 300 in one cycle.
  - Required: wr_conflict = 1 for one cycle. A following read of 300 returns 0xCC. The LVT entry is 6.
- Read-during-write, BYPASS=0:
  - Stimulus: address 7 holds 0x11; in the same cycle, port 3 writes 0x22 to address 7 and read port 0 reads address 7.
  - Required: r_dout_0 = 0x11; the next-cycle read returns 0x22.
- Read-during-write, BYPASS=1:
  - Stimulus: same as the previous scenario.
  - Required: r_dout_0 = 0x22 in the same cycle.
- Mid-operation clear and reset:
  - Stimulus: write 0x55 to address 9; pulse clr; assert a write to 9 during busy; then pulse rst at cycle 1000 of CLEAR.
  - Required: the busy window restarts at 2048 cycles after rst. The final read of 9 returns 0, and wr_conflict never asserts.
